// File: rtl/fp32_operand_serializer.sv
// Purpose: accepts an FP32 operand pair, pulses go, then streams A then B MSB-first onto inpab for a serial adder.
// Latency: accept edge -> go high next cycle; first bit consumable the cycle after go; 64 strobed bits then wait for done.
// Backpressure: in_ready only in IDLE; shift=0 stalls the stream indefinitely; next pair held off until adder_done.
module fp32_operand_serializer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             shift,
    input  logic             adder_done,
    output logic             go,
    output logic             inpab,
    output logic             busy,
    output logic             err
);

    localparam int FRAME = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GO        = 2'd1,
        ST_SEND      = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [FRAME-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             err_q, err_nxt;
    logic             go_q, inpab_q;
    logic             go_nxt, inpab_nxt;

    // The accept handshake is only offered from IDLE and never while reset is held.
    assign in_ready = (state == ST_IDLE) && reset;
    assign busy     = (state != ST_IDLE);
    assign go       = go_q;
    assign inpab    = inpab_q;
    assign err      = err_q;

    // Next-state logic: frame sequencing, bit shifting and protocol-error detection.
    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        count_nxt = count;
        err_nxt   = err_q;
        case (state)
            ST_IDLE: begin
                // shift and adder_done are don't-cares here and never flag an error.
                if (in_valid && in_ready) begin
                    shreg_nxt = {op_a, op_b};
                    count_nxt = '0;
                    err_nxt   = 1'b0;
                    state_nxt = ST_GO;
                end
            end
            ST_GO: begin
                if (adder_done) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    // The adder cannot consume a bit while it is being started.
                    if (shift) begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (adder_done) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (shift) begin
                    shreg_nxt = shreg << 1;
                    // Exit is decided on the pre-increment count so the counter never wraps.
                    if (count == LAST_BIT) begin
                        state_nxt = ST_WAIT_DONE;
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (shift) begin
                    err_nxt = 1'b1;
                end
                if (adder_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are precomputed from next state so go and inpab come straight from flops.
    always_comb begin
        go_nxt    = (state_nxt == ST_GO);
        inpab_nxt = 1'b0;
        if ((state_nxt == ST_GO) || (state_nxt == ST_SEND)) begin
            inpab_nxt = shreg_nxt[FRAME-1];
        end
    end

    // State and output registers; reset drops everything immediately, abandoning any partial frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            count   <= '0;
            err_q   <= 1'b0;
            go_q    <= 1'b0;
            inpab_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            count   <= count_nxt;
            err_q   <= err_nxt;
            go_q    <= go_nxt;
            inpab_q <= inpab_nxt;
        end
    end

endmodule
